fml_arb2: RTL and testbench
===========================

// Module: fml_arb2
// PURPOSE
//  Two-master FML arbiter sitting directly upstream of the PSRAM controller: merges CPU (m0) and DMA/video (m1) FML
//  master ports onto the single FML slave port of the controller. Round-robin (or fixed) arbitration, grant held for
//  a whole transaction/burst, one idle gap cycle between transactions, and a watchdog that frees a stuck grant.
// PARAMETERS
//  ADR_W       23    FML word address width (matches controller fml_adr)
//  PRIO_FIXED  0     0: round-robin between m0/m1; 1: m0 always wins a simultaneous request
//  TIMEOUT     1023  max cycles a grant may wait for s_eack before forced release (10-bit counter, 1..1023)
// PORTS
//  clk           in   1      system clock (100 MHz)
//  rst           in   1      asynchronous reset, active-high
//  ctrl_ready    in   1      controller_ready from PSRAM controller; no grant issued while 0
//  mN_adr        in   ADR_W  master N address (N = 0, 1)
//  mN_stb        in   1      master N strobe; held until mN_eack of last beat
//  mN_we         in   1      master N write enable
//  mN_cti        in   3      master N cycle type: 0 single, 2 incrementing burst, 7 end of burst
//  mN_sel        in   4      master N byte selects
//  mN_di         in   32     master N write data
//  mN_eack       out  1      ack to master N (gated copy of s_eack)
//  mN_do         out  32     read data to master N (s_do broadcast)
//  s_adr         out  ADR_W  to controller fml_adr
//  s_stb/s_we    out  1/1    to controller fml_stb/fml_we
//  s_cti/s_sel   out  3/4    to controller fml_cti/fml_sel
//  s_di          out  32     to controller fml_di
//  s_eack        in   1      controller fml_eack
//  s_do          in   32     controller fml_do
//  timeout_err   out  1      one-cycle pulse when watchdog forces a release
// BEHAVIOUR
//  - States: IDLE, GNT0, GNT1, GAP. State, last-granted flag (last), watchdog count are registers.
//  - Reset: state=IDLE, last=1 (so m0 wins first tie), count=0, timeout_err=0; hence all s_* outputs, mN_eack = 0.
//  - s_* outputs combinational from state: GNT0 -> m0_* passed through, GNT1 -> m1_*; IDLE/GAP -> all s_* = 0.
//  - mN_eack = s_eack & (state==GNTN); mN_do = s_do always.
//  - IDLE: if !ctrl_ready stay. Else req0=m0_stb, req1=m1_stb. One request -> grant it. Both -> PRIO_FIXED?m0:
//    (last==0 ? m1 : m0). Grant takes effect next cycle (1-cycle arbitration latency); last<=granted index; count<=0.
//  - GNTN, s_eack=1 and mN_cti in {0,7} -> GAP (transaction complete). s_eack=1 with cti=2 -> stay (burst beat), count<=0.
//  - GNTN, mN_stb=0 (master abort) -> GAP; controller returns to idle on stb low.
//  - GNTN, no s_eack: count++; count==TIMEOUT-1 -> GAP, timeout_err=1 for that one transition cycle.
//  - GAP: exactly one cycle, s_stb=0, then IDLE. Guarantees controller has left its ack state and seen stb low
//    before the next grant (controller refuses new request while its eack is high).
//  - Simultaneous s_eack and watchdog expiry: treat as normal completion, no timeout_err.
//  - s_eack while IDLE/GAP: ignored, routed to no master.
//  - Non-granted master's stb is held off (no eack) until its grant; its request is never dropped, only delayed.
//  - Round-robin fairness: with both stb continuously high, grants alternate m0,m1,m0,... (PRIO_FIXED=0).
//  - ctrl_ready falling while granted does not break grant; only checked in IDLE.
//  - rst asserted mid-transaction: immediate return to IDLE, s_stb drops asynchronously, no eack delivered.
// TESTING
//  - Single: m0 write adr=0x000100, di=0xDEADBEEF, sel=0xF, cti=0 -> s_stb rises 1 cycle after m0_stb, fields
//    match, m0_eack on s_eack, m1_eack stays 0, then 1 GAP cycle with s_stb=0.
//  - Tie: m0_stb, m1_stb both rise in IDLE after reset -> GNT0 first, then GNT1; repeat 4 times -> strict alternation;
//    PRIO_FIXED=1 -> m0 granted every time while it requests.
//  - Burst: m1 read cti=2 with 3 acks then cti=7 ack -> grant held across all 4 s_eack, m1_do = s_do each beat, no m0
//    grant in between even with m0_stb high.
//  - Watchdog: TIMEOUT=16, grant m0, never assert s_eack -> release after 16 cycles, timeout_err pulses once, m1 granted next.
//  - Startup: ctrl_ready=0 with m0_stb=1 -> s_stb stays 0; ctrl_ready rises -> grant next cycle.
//  - Reset mid-burst: assert rst during GNT1 beat 2 -> s_stb, m1_eack = 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/fml_arb2.sv
// fml_arb2: two-master FML arbiter feeding the PSRAM controller's single FML slave port.
// m0 (CPU) and m1 (DMA/video) share the slave; the grant is held for a whole transaction or
// burst, every transaction is followed by one idle gap cycle, and a watchdog releases a grant
// whose slave never acknowledges.
module fml_arb2 #(
  parameter int unsigned ADR_W      = 23,
  parameter bit          PRIO_FIXED = 1'b0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_ready,

  input  logic [ADR_W-1:0] m0_adr,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [2:0]       m0_cti,
  input  logic [3:0]       m0_sel,
  input  logic [31:0]      m0_di,
  output logic             m0_eack,
  output logic [31:0]      m0_do,

  input  logic [ADR_W-1:0] m1_adr,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [2:0]       m1_cti,
  input  logic [3:0]       m1_sel,
  input  logic [31:0]      m1_di,
  output logic             m1_eack,
  output logic [31:0]      m1_do,

  output logic [ADR_W-1:0] s_adr,
  output logic             s_stb,
  output logic             s_we,
  output logic [2:0]       s_cti,
  output logic [3:0]       s_sel,
  output logic [31:0]      s_di,
  input  logic             s_eack,
  input  logic [31:0]      s_do,

  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Cycle-type codes that close a transaction on their ack.
  localparam logic [2:0] CTI_SINGLE = 3'd0;
  localparam logic [2:0] CTI_END    = 3'd7;

  // Watchdog fires on the cycle the count reaches its last value, giving TIMEOUT granted cycles.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;   // index of the most recently granted master
  logic [9:0]  count_q, count_d; // granted cycles without an ack
  logic        terr_q, terr_d;
  logic        pick_m1;          // arbitration decision while idle

  // State, last-granted flag, watchdog count and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      count_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      terr_q  <= terr_d;
    end
  end

  // Slave-side mux: the granted master is passed straight through, everything else reads as zero.
  always_comb begin
    s_adr = '0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_cti = '0;
    s_sel = '0;
    s_di  = '0;
    case (state_q)
      GNT0: begin
        s_adr = m0_adr;
        s_stb = m0_stb;
        s_we  = m0_we;
        s_cti = m0_cti;
        s_sel = m0_sel;
        s_di  = m0_di;
      end
      GNT1: begin
        s_adr = m1_adr;
        s_stb = m1_stb;
        s_we  = m1_we;
        s_cti = m1_cti;
        s_sel = m1_sel;
        s_di  = m1_di;
      end
      default: ;
    endcase
  end

  // Idle arbitration: a lone request wins; a tie goes to m0 when fixed, otherwise to the master not served last.
  always_comb begin
    pick_m1 = 1'b0;
    if (m0_stb && m1_stb) begin
      pick_m1 = !PRIO_FIXED && !last_q;
    end else if (m1_stb) begin
      pick_m1 = 1'b1;
    end
  end

  // Next-state logic: grant from idle, hold through bursts, release on completion/abort/watchdog, one gap cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_ready && (m0_stb || m1_stb)) begin
          state_d = pick_m1 ? GNT1 : GNT0;
          last_d  = pick_m1;
          count_d = '0;
        end
      end
      GNT0, GNT1: begin
        // s_stb/s_cti already carry the granted master's strobe and cycle type.
        if (!s_stb) begin
          state_d = GAP;
        end else if (s_eack) begin
          count_d = '0;
          if (s_cti == CTI_SINGLE || s_cti == CTI_END) begin
            state_d = GAP;
          end
        end else if (count_q == CNT_LAST) begin
          state_d = GAP;
          terr_d  = 1'b1;
        end else begin
          count_d = count_q + 10'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_eack     = s_eack && (state_q == GNT0);
  assign m1_eack     = s_eack && (state_q == GNT1);
  assign m0_do       = s_do;
  assign m1_do       = s_do;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_fml_arb2.sv
// Directed bench for fml_arb2: a round-robin instance (TIMEOUT=16) and a fixed-priority
// instance share all inputs; expected grants are hand-computed per cycle.
module tb_fml_arb2;

  localparam int unsigned ADR_W = 23;
  localparam logic [ADR_W-1:0] A0 = 23'h000100;
  localparam logic [ADR_W-1:0] A1 = 23'h0002A5;
  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'h12345678;

  logic clk = 1'b0;
  logic rst, ctrl_ready;
  logic [ADR_W-1:0] m0_adr, m1_adr;
  logic m0_stb, m0_we, m1_stb, m1_we;
  logic [2:0] m0_cti, m1_cti;
  logic [3:0] m0_sel, m1_sel;
  logic [31:0] m0_di, m1_di, s_do;
  logic s_eack;

  logic m0_eack, m1_eack, timeout_err;
  logic [31:0] m0_do, m1_do, s_di;
  logic [ADR_W-1:0] s_adr;
  logic s_stb, s_we;
  logic [2:0] s_cti;
  logic [3:0] s_sel;

  logic f_m0_eack, f_m1_eack, f_timeout_err;
  logic [31:0] f_m0_do, f_m1_do, f_s_di;
  logic [ADR_W-1:0] f_s_adr;
  logic f_s_stb, f_s_we;
  logic [2:0] f_s_cti;
  logic [3:0] f_s_sel;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fml_arb2 #(.ADR_W(ADR_W), .PRIO_FIXED(1'b0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ctrl_ready(ctrl_ready),
    .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_cti(m0_cti), .m0_sel(m0_sel),
    .m0_di(m0_di), .m0_eack(m0_eack), .m0_do(m0_do),
    .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_cti(m1_cti), .m1_sel(m1_sel),
    .m1_di(m1_di), .m1_eack(m1_eack), .m1_do(m1_do),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_cti(s_cti), .s_sel(s_sel), .s_di(s_di),
    .s_eack(s_eack), .s_do(s_do), .timeout_err(timeout_err)
  );

  fml_arb2 #(.ADR_W(ADR_W), .PRIO_FIXED(1'b1), .TIMEOUT(1023)) dut_fix (
    .clk(clk), .rst(rst), .ctrl_ready(ctrl_ready),
    .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_cti(m0_cti), .m0_sel(m0_sel),
    .m0_di(m0_di), .m0_eack(f_m0_eack), .m0_do(f_m0_do),
    .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_cti(m1_cti), .m1_sel(m1_sel),
    .m1_di(m1_di), .m1_eack(f_m1_eack), .m1_do(f_m1_do),
    .s_adr(f_s_adr), .s_stb(f_s_stb), .s_we(f_s_we), .s_cti(f_s_cti), .s_sel(f_s_sel),
    .s_di(f_s_di), .s_eack(s_eack), .s_do(s_do), .timeout_err(f_timeout_err)
  );

  typedef struct {
    logic       rdy;
    logic       s0;
    logic [2:0] c0;
    logic       s1;
    logic [2:0] c1;
    logic       ack;
    int         g;     // expected grant: 0 none, 1 m0, 2 m1
    logic       terr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic s0, input logic [2:0] c0,
                              input logic s1, input logic [2:0] c1, input logic ack,
                              input int g, input logic terr);
    vec_t v;
    v.rdy = rdy; v.s0 = s0; v.c0 = c0; v.s1 = s1; v.c1 = c1; v.ack = ack;
    v.g = g; v.terr = terr;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle before checking.
  task automatic drive(input logic rdy, input logic s0, input logic [2:0] c0,
                       input logic s1, input logic [2:0] c1, input logic ack);
    @(negedge clk);
    ctrl_ready = rdy;
    m0_stb = s0; m0_cti = c0;
    m1_stb = s1; m1_cti = c1;
    s_eack = ack;
    s_do = $urandom;
    #1;
  endtask

  task automatic check(input string name, input int g, input logic terr);
    logic             e_stb, e_we;
    logic [ADR_W-1:0] e_adr;
    logic [31:0]      e_di;
    logic [2:0]       e_cti;
    logic [3:0]       e_sel;
    e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_di = '0; e_cti = '0; e_sel = '0;
    if (g == 1) begin
      e_stb = m0_stb; e_we = 1'b1; e_adr = A0; e_di = D0; e_cti = m0_cti; e_sel = 4'hF;
    end else if (g == 2) begin
      e_stb = m1_stb; e_we = 1'b0; e_adr = A1; e_di = D1; e_cti = m1_cti; e_sel = 4'h3;
    end
    cmp({name, ".s_stb"}, 64'(s_stb), 64'(e_stb));
    cmp({name, ".s_adr"}, 64'(s_adr), 64'(e_adr));
    cmp({name, ".s_di"},  64'(s_di),  64'(e_di));
    cmp({name, ".s_we"},  64'(s_we),  64'(e_we));
    cmp({name, ".s_cti"}, 64'(s_cti), 64'(e_cti));
    cmp({name, ".s_sel"}, 64'(s_sel), 64'(e_sel));
    cmp({name, ".m0_eack"}, 64'(m0_eack), 64'(s_eack && g == 1));
    cmp({name, ".m1_eack"}, 64'(m1_eack), 64'(s_eack && g == 2));
    cmp({name, ".m0_do"}, 64'(m0_do), 64'(s_do));
    cmp({name, ".m1_do"}, 64'(m1_do), 64'(s_do));
    cmp({name, ".timeout_err"}, 64'(timeout_err), 64'(terr));
  endtask

  task automatic check_fix(input string name, input int g);
    cmp({name, ".fix_s_adr"}, 64'(f_s_adr), (g == 1) ? 64'(A0) : (g == 2) ? 64'(A1) : 64'd0);
    cmp({name, ".fix_m0_eack"}, 64'(f_m0_eack), 64'(s_eack && g == 1));
    cmp({name, ".fix_m1_eack"}, 64'(f_m1_eack), 64'(s_eack && g == 2));
  endtask

  vec_t vecs[26];

  initial begin
    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);  // single write m0: request seen in IDLE
    vecs[1]  = mk(1, 1, 0, 0, 0, 0, 1, 0);  // granted one cycle later
    vecs[2]  = mk(1, 1, 0, 0, 0, 1, 1, 0);  // ack -> m0_eack
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0);  // GAP
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0);  // IDLE
    vecs[5]  = mk(1, 0, 0, 0, 0, 1, 0, 0);  // stray ack in IDLE goes nowhere
    vecs[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0);  // controller not ready: no grant
    vecs[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 0, 0);  // ready rises
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 1, 0);  // ready drop does not break grant
    vecs[10] = mk(0, 1, 0, 0, 0, 1, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0);  // GAP
    vecs[12] = mk(1, 1, 0, 1, 2, 0, 0, 0);  // tie, m0 served last -> m1 burst
    vecs[13] = mk(1, 1, 0, 1, 2, 1, 2, 0);  // beat 1
    vecs[14] = mk(1, 1, 0, 1, 2, 0, 2, 0);  // wait state
    vecs[15] = mk(1, 1, 0, 1, 2, 1, 2, 0);  // beat 2
    vecs[16] = mk(1, 1, 0, 1, 2, 1, 2, 0);  // beat 3
    vecs[17] = mk(1, 1, 0, 1, 7, 1, 2, 0);  // end of burst
    vecs[18] = mk(1, 1, 0, 0, 0, 0, 0, 0);  // GAP with m0 still waiting
    vecs[19] = mk(1, 1, 0, 0, 0, 0, 0, 0);  // IDLE -> m0
    vecs[20] = mk(1, 1, 0, 0, 0, 1, 1, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 0);  // GAP
    vecs[22] = mk(1, 0, 0, 1, 0, 0, 0, 0);  // m1 request
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 2, 0);  // m1 aborts: granted but stb low
    vecs[24] = mk(1, 0, 0, 0, 0, 1, 0, 0);  // GAP ignores ack
    vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 0);  // IDLE

    rst = 1'b1; ctrl_ready = 1'b1;
    m0_adr = A0; m0_we = 1'b1; m0_sel = 4'hF; m0_di = D0; m0_stb = 1'b1; m0_cti = 3'd0;
    m1_adr = A1; m1_we = 1'b0; m1_sel = 4'h3; m1_di = D1; m1_stb = 1'b1; m1_cti = 3'd0;
    s_eack = 1'b0; s_do = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset", 0, 1'b0);
    check_fix("reset", 0);
    m0_stb = 1'b0; m1_stb = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].rdy, vecs[i].s0, vecs[i].c0, vecs[i].s1, vecs[i].c1, vecs[i].ack);
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].terr);
    end

    // Tie from reset: round-robin alternates starting with m0; fixed priority always m0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      drive(1, 1, 0, 1, 0, 0);
      check($sformatf("tie%0d.idle", t), 0, 1'b0);
      check_fix($sformatf("tie%0d.idle", t), 0);
      drive(1, 1, 0, 1, 0, 1);
      check($sformatf("tie%0d.gnt", t), (t % 2 == 0) ? 1 : 2, 1'b0);
      check_fix($sformatf("tie%0d.gnt", t), 1);
      drive(1, 1, 0, 1, 0, 0);
      check($sformatf("tie%0d.gap", t), 0, 1'b0);
      check_fix($sformatf("tie%0d.gap", t), 0);
    end

    // Watchdog: m0 wins (m1 served last), never acked for 16 cycles.
    drive(1, 1, 0, 1, 0, 0);
    check("wd.idle", 0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      drive(1, 1, 0, 1, 0, 0);
      check($sformatf("wd.hold%0d", k), 1, 1'b0);
    end
    drive(1, 1, 0, 1, 0, 0);
    check("wd.gap_err", 0, 1'b1);
    drive(1, 1, 0, 1, 0, 0);
    check("wd.idle2", 0, 1'b0);
    // m1 next; ack lands exactly on the expiry cycle: normal completion.
    for (int k = 0; k < 15; k++) begin
      drive(1, 1, 0, 1, 0, 0);
      check($sformatf("wd.m1wait%0d", k), 2, 1'b0);
    end
    drive(1, 1, 0, 1, 0, 1);
    check("wd.m1ack_at_expiry", 2, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    check("wd.gap_no_err", 0, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    check("wd.idle3", 0, 1'b0);

    // Reset during an m1 burst.
    drive(1, 0, 0, 1, 2, 0);
    check("rb.idle", 0, 1'b0);
    drive(1, 0, 0, 1, 2, 1);
    check("rb.beat1", 2, 1'b0);
    drive(1, 0, 0, 1, 2, 1);
    check("rb.beat2", 2, 1'b0);
    rst = 1'b1; #1;
    check("rb.in_reset", 0, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    check("rb.held", 0, 1'b0);
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0);
    check("rb.after_idle", 0, 1'b0);
    drive(1, 0, 0, 1, 0, 1);
    check("rb.regrant", 2, 1'b0);
    drive(1, 0, 0, 0, 0, 0);
    check("rb.gap", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
